// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshake and a 2-entry skid buffer (main + skid). in_ready and out_valid
// are registered, so there is no combinational path from out_ready to in_ready.
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating stall/flush
// performance counters; without it stall_cnt and flush_cnt are tied to zero.
module pipe_stage_reg #(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q;
   logic              in_ready_q;
   logic              accept_s;
   logic              take_s;

   assign accept_s  = in_valid && in_ready_q;
   assign take_s    = out_valid_q && out_ready;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

   // Next-state and payload selection; flush squashes everything held.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = FLUSH_VAL;
         skid_d  = FLUSH_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_d = ST_ONE;
                  main_d  = in_data;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && take_s) begin
                  main_d = in_data;
               end else if (accept_s) begin
                  state_d = ST_FULL;
                  skid_d  = in_data;
               end else if (take_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a take can move the state;
               // the older main entry leaves first and skid moves up.
               if (take_s) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = FLUSH_VAL;
               skid_d  = FLUSH_VAL;
            end
         endcase
      end
   end

   // State, payload and registered handshake outputs derived from next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_q      <= FLUSH_VAL;
         skid_q      <= FLUSH_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= (state_d != ST_EMPTY);
         in_ready_q  <= (state_d != ST_FULL);
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Saturating counters: stalled cycles and flushes that squashed data.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
         if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_cnt_q <= flush_cnt_q;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = {CNT_W{1'b0}};
   assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
